router_sync_np: RTL and testbench
=================================

// Module: router_sync_np
// PURPOSE
//  Parametrised synchroniser between the router FSM and NUM_PORTS output FIFOs.
//  Latches the destination address on detect_add, steers write enable and FIFO-full
//  status to/from the addressed FIFO, and drives per-port valid. Runs a per-port stall
//  timer that issues a one-cycle soft reset when a port is valid but unread for TIMEOUT cycles.
//  Flags out-of-range addresses. Sits between router_fsm and the router_fifo instances.
// PARAMETERS
//  NUM_PORTS  3   number of output FIFOs/ports (1..2**ADDR_W)
//  ADDR_W     2   width of destination address field datain
//  TIMEOUT    30  consecutive stalled cycles before soft reset (2..2**CNT_W-1)
//  CNT_W      5   width of each per-port stall counter
// PORTS
//  clk            in   1          clock; all state updates on rising edge
//  reset          in   1          synchronous, active-high reset
//  detect_add     in   1          capture datain as destination address this cycle
//  datain         in   ADDR_W     destination address field of header byte
//  write_enb_reg  in   1          FSM request to write current byte to addressed FIFO
//  read_enb       in   NUM_PORTS  per-port read enable from receiving side
//  empty          in   NUM_PORTS  per-port FIFO empty
//  full           in   NUM_PORTS  per-port FIFO full
//  vld_out        out  NUM_PORTS  per-port data valid
//  write_enb      out  NUM_PORTS  one-hot (or zero) FIFO write enable
//  fifo_full      out  1          full status of addressed FIFO
//  soft_reset     out  NUM_PORTS  per-port one-cycle soft-reset pulse (registered)
//  addr_err       out  1          latched address is >= NUM_PORTS (registered)
// BEHAVIOUR
//  Reset (reset=1 at edge): addr_q=0, addr_err=0, all stall counters=0, soft_reset=0.
//   Combinational outputs after reset: write_enb=0 unless write_enb_reg, fifo_full=full[0].
//  Address latch: detect_add=1 -> addr_q<=datain, addr_err<=(datain>=NUM_PORTS) next edge.
//   Otherwise addr_q/addr_err hold. detect_add and write_enb_reg in same cycle: write_enb
//   uses the OLD addr_q (latch takes effect next cycle).
//  write_enb (comb): write_enb_reg & !addr_err -> bit addr_q set, all others 0; else all 0.
//  fifo_full (comb): full[addr_q] when !addr_err; 0 when addr_err.
//  vld_out[i] (comb) = !empty[i]; zero latency.
//  Stall timer, per port i, independent:
//   stall_i = vld_out[i] & !read_enb[i].
//   !stall_i -> cnt_i<=0, soft_reset[i]<=0.
//   stall_i & cnt_i!=TIMEOUT-1 -> cnt_i<=cnt_i+1, soft_reset[i]<=0.
//   stall_i & cnt_i==TIMEOUT-1 -> cnt_i<=0, soft_reset[i]<=1 (exactly one cycle).
//   => soft_reset[i] high in the cycle after the edge sampling the TIMEOUT-th consecutive
//      stalled cycle; continued stall re-fires every TIMEOUT cycles. Counter never wraps.
//   read_enb[i] on any cycle, or empty[i] rising, restarts count from 0.
//  Multiple ports may time out on the same edge; pulses are independent.
//  Reset mid-count: counters and pending pulses cleared at that edge; no pulse emitted.
//  No X on outputs: every register has a defined reset value.
// TESTING
//  1 reset=1 two cycles -> soft_reset=0, addr_err=0, write_enb=0; cnt all 0.
//  2 detect_add, datain=2, then write_enb_reg=1 -> write_enb=3'b100; full[2]=1 -> fifo_full=1.
//  3 datain=3 (NUM_PORTS=3) latched, write_enb_reg=1 -> addr_err=1, write_enb=0, fifo_full=0.
//  4 empty[1]=0, read_enb[1]=0 held 30 cycles -> soft_reset[1]=1 for exactly cycle 31;
//    held 60 cycles -> second pulse at cycle 61.
//  5 stall port 0 for 29 cycles, read_enb[0]=1 one cycle, stall again -> no pulse until
//    30 further stalled cycles.
//  6 reset asserted at stall cycle 29 on ports 0 and 2 -> no soft_reset; restart counts 0.
//  Also: NUM_PORTS=4, ADDR_W=2, TIMEOUT=5 regression of scenarios 2-4.

Source files
------------

// File: rtl/router_sync_np.sv
// Address latch, write-enable/full steering and per-port stall timers between
// the router FSM and its NUM_PORTS output FIFOs.
module router_sync_np #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int TIMEOUT   = 30,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    datain,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] full,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 addr_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 addr_err_q, addr_err_d;
  logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] soft_reset_q, soft_reset_d;
  logic [NUM_PORTS-1:0] stall;

  // A new header only takes effect from the next cycle; a same-cycle write uses the old address.
  always_comb begin
    addr_d     = addr_q;
    addr_err_d = addr_err_q;
    if (detect_add) begin
      addr_d     = datain;
      addr_err_d = (int'(datain) >= NUM_PORTS);
    end
  end

  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!addr_err_q && (addr_q == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out = ~empty;
  assign stall   = vld_out & ~read_enb;

  // Counter returns to zero on the firing edge, so a persistent stall re-fires every TIMEOUT cycles.
  always_comb begin
    soft_reset_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = '0;
      if (stall[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          soft_reset_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      addr_err_q   <= 1'b0;
      soft_reset_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      addr_q       <= addr_d;
      addr_err_q   <= addr_err_d;
      soft_reset_q <= soft_reset_d;
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign soft_reset = soft_reset_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_router_sync_np.sv
// Directed bench for router_sync_np: default 3-port build plus a 4-port,
// TIMEOUT=5 build for the address-steering and stall-timer regressions.
module tb_router_sync_np;

  logic       clk = 1'b0;
  logic       reset;
  logic       detect_add, write_enb_reg;
  logic [1:0] datain;
  logic [2:0] read_enb, empty, full;
  logic [2:0] vld_out, write_enb, soft_reset;
  logic       fifo_full, addr_err;

  logic       detect_add4, write_enb_reg4;
  logic [1:0] datain4;
  logic [3:0] read_enb4, empty4, full4;
  logic [3:0] vld_out4, write_enb4, soft_reset4;
  logic       fifo_full4, addr_err4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_sync_np dut (
    .clk(clk), .reset(reset), .detect_add(detect_add), .datain(datain),
    .write_enb_reg(write_enb_reg), .read_enb(read_enb), .empty(empty), .full(full),
    .vld_out(vld_out), .write_enb(write_enb), .fifo_full(fifo_full),
    .soft_reset(soft_reset), .addr_err(addr_err)
  );

  router_sync_np #(.NUM_PORTS(4), .ADDR_W(2), .TIMEOUT(5), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset), .detect_add(detect_add4), .datain(datain4),
    .write_enb_reg(write_enb_reg4), .read_enb(read_enb4), .empty(empty4), .full(full4),
    .vld_out(vld_out4), .write_enb(write_enb4), .fifo_full(fifo_full4),
    .soft_reset(soft_reset4), .addr_err(addr_err4)
  );

  typedef struct {
    logic       da;
    logic [1:0] din;
    logic       wr;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] exp_we;
    logic       exp_ff;
    logic       exp_err;
    logic [2:0] exp_vld;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    // Idle drive: all FIFOs empty, every port reading.
    reset = 1'b1; detect_add = 0; datain = 0; write_enb_reg = 0;
    read_enb = 3'b111; empty = 3'b111; full = 3'b010;
    detect_add4 = 0; datain4 = 0; write_enb_reg4 = 0;
    read_enb4 = 4'hf; empty4 = 4'hf; full4 = 4'h0;

    // Address steering table: comb outputs checked against state latched by earlier rows.
    vecs[0] = '{1'b0, 2'd0, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 1'b0, 3'b000};
    vecs[1] = '{1'b1, 2'd2, 1'b1, 3'b000, 3'b110, 3'b001, 1'b0, 1'b0, 3'b001};
    vecs[2] = '{1'b0, 2'd0, 1'b1, 3'b100, 3'b101, 3'b100, 1'b1, 1'b0, 3'b010};
    vecs[3] = '{1'b0, 2'd0, 1'b0, 3'b011, 3'b011, 3'b000, 1'b0, 1'b0, 3'b100};
    vecs[4] = '{1'b1, 2'd3, 1'b1, 3'b100, 3'b000, 3'b100, 1'b1, 1'b0, 3'b111};
    vecs[5] = '{1'b0, 2'd0, 1'b1, 3'b111, 3'b100, 3'b000, 1'b0, 1'b1, 3'b011};
    vecs[6] = '{1'b1, 2'd1, 1'b0, 3'b111, 3'b010, 3'b000, 1'b0, 1'b1, 3'b101};
    vecs[7] = '{1'b0, 2'd0, 1'b1, 3'b010, 3'b001, 3'b010, 1'b1, 1'b0, 3'b110};
    vecs[8] = '{1'b0, 2'd0, 1'b1, 3'b101, 3'b111, 3'b010, 1'b0, 1'b0, 3'b000};

    // Reset state
    tick(); tick();
    chk("rst_soft_reset", 32'(soft_reset), 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'h0);
    chk("rst_write_enb", 32'(write_enb), 32'h0);
    chk("rst_fifo_full", 32'(fifo_full), 32'h0);
    full = 3'b001; #1;
    chk("rst_fifo_full_p0", 32'(fifo_full), 32'h1);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      detect_add = vecs[v].da; datain = vecs[v].din; write_enb_reg = vecs[v].wr;
      full = vecs[v].full; empty = vecs[v].empty;
      #1;
      chk($sformatf("vec%0d_write_enb", v), 32'(write_enb), 32'(vecs[v].exp_we));
      chk($sformatf("vec%0d_fifo_full", v), 32'(fifo_full), 32'(vecs[v].exp_ff));
      chk($sformatf("vec%0d_addr_err", v), 32'(addr_err), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_vld_out", v), 32'(vld_out), 32'(vecs[v].exp_vld));
      chk($sformatf("vec%0d_soft_reset", v), 32'(soft_reset), 32'h0);
      tick();
    end
    detect_add = 0; write_enb_reg = 0;

    // Port 1 held valid and unread: pulses after 30th and 60th stalled cycles.
    empty = 3'b101; read_enb = 3'b000;
    for (int k = 1; k <= 60; k++) begin
      tick();
      chk($sformatf("stall_p1_k%0d", k), 32'(soft_reset), (k % 30 == 0) ? 32'h2 : 32'h0);
    end

    // Port 0: 29 stalls, one read, then 30 more stalls before a pulse.
    empty = 3'b110;
    for (int k = 1; k <= 60; k++) begin
      read_enb = (k == 30) ? 3'b001 : 3'b000;
      tick();
      chk($sformatf("restart_p0_k%0d", k), 32'(soft_reset), (k == 60) ? 32'h1 : 32'h0);
    end
    read_enb = 3'b000;

    // Ports 0 and 2 stalled; reset on stall cycle 29 cancels the pending timeout.
    empty = 3'b010;
    for (int k = 1; k <= 59; k++) begin
      reset = (k == 29);
      tick();
      chk($sformatf("rst_mid_k%0d", k), 32'(soft_reset), (k == 59) ? 32'h5 : 32'h0);
    end
    reset = 1'b0;
    tick();
    chk("rst_mid_one_cycle", 32'(soft_reset), 32'h0);
    empty = 3'b111; read_enb = 3'b111;

    // Four-port, TIMEOUT=5 build
    detect_add4 = 1; datain4 = 2'd2; full4 = 4'b0100;
    tick();
    detect_add4 = 0; write_enb_reg4 = 1; #1;
    chk("p4_write_enb_a2", 32'(write_enb4), 32'h4);
    chk("p4_fifo_full_a2", 32'(fifo_full4), 32'h1);
    detect_add4 = 1; datain4 = 2'd3; full4 = 4'b1000;
    tick();
    detect_add4 = 0; #1;
    chk("p4_write_enb_a3", 32'(write_enb4), 32'h8);
    chk("p4_fifo_full_a3", 32'(fifo_full4), 32'h1);
    chk("p4_addr_err_a3", 32'(addr_err4), 32'h0);
    write_enb_reg4 = 0; #1;
    chk("p4_write_enb_idle", 32'(write_enb4), 32'h0);

    empty4 = 4'b1101; read_enb4 = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("p4_stall_p1_k%0d", k), 32'(soft_reset4), (k % 5 == 0) ? 32'h2 : 32'h0);
    end
    chk("p4_vld_out", 32'(vld_out4), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
